// File: rtl/sys_array_pkg.sv
// Shared constants, state encoding and packing helper for the 3x3 systolic array front end.
// Matrix elements are packed row-major, element (r,c) in slice r*N+c of a bus.
package sys_array_pkg;

    localparam int N      = 3;
    localparam int DATA_W = 16;
    localparam int BUS_W  = N * N * DATA_W;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_FEED,
        ST_FLUSH,
        ST_DONE
    } state_t;

    function automatic int slice_idx(input int r, input int c);
        return r * N + c;
    endfunction

endpackage

// File: rtl/sys_array_feeder.sv
// Latches two operand matrices, clears the systolic array, then injects A rows on the left
// edge and B columns on the top edge with one-cycle-per-lane skew, flushes, and flags done.
//
// state | meaning
// IDLE  | waiting for start; buses zero
// CLEAR | array_clear high for one cycle
// FEED  | skewed injection, step t = 0 .. 2N-2
// FLUSH | buses zero while the last products drain through the grid
// DONE  | one-cycle done pulse, array result is final
module sys_array_feeder
    import sys_array_pkg::*;
#(
    parameter int FLUSH_CYC = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [BUS_W-1:0] mat_a,
    input  logic [BUS_W-1:0] mat_b,
    output logic             array_clear,
    output logic [BUS_W-1:0] data_in_1,
    output logic [BUS_W-1:0] data_in_a,
    output logic             busy,
    output logic             done
);

    localparam int CNT_MAX = (2 * N - 1 > FLUSH_CYC) ? 2 * N - 1 : FLUSH_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] FEED_LAST  = CNT_W'(2 * N - 2);
    localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYC);

    state_t                      state;
    logic [CNT_W-1:0]            cnt;
    logic [CNT_W-1:0]            step_nxt;
    logic [N*N-1:0][DATA_W-1:0]  a_q;
    logic [N*N-1:0][DATA_W-1:0]  b_q;
    logic [N*N-1:0][DATA_W-1:0]  left_bus;
    logic [N*N-1:0][DATA_W-1:0]  top_bus;
    logic [N-1:0][DATA_W-1:0]    left_lane;
    logic [N-1:0][DATA_W-1:0]    top_lane;

    // Outputs are registered, so the buses are loaded with the values for the step being entered.
    assign step_nxt = (state == ST_CLEAR) ? '0 : cnt + 1'b1;

    for (genvar i = 0; i < N; i++) begin : g_lane
        logic [N-1:0][DATA_W-1:0] left_terms;
        logic [N-1:0][DATA_W-1:0] top_terms;
        logic [DATA_W-1:0]        left_or;
        logic [DATA_W-1:0]        top_or;

        // Lane i carries element k at step i+k: A[i][k] on the left, B[k][i] on top.
        for (genvar k = 0; k < N; k++) begin : g_elem
            localparam int               A_IDX = slice_idx(i, k);
            localparam int               B_IDX = slice_idx(k, i);
            localparam logic [CNT_W-1:0] STEP  = CNT_W'(i + k);

            assign left_terms[k] = (step_nxt == STEP) ? a_q[A_IDX] : '0;
            assign top_terms[k]  = (step_nxt == STEP) ? b_q[B_IDX] : '0;
        end

        always_comb begin
            left_or = '0;
            top_or  = '0;
            for (int k = 0; k < N; k++) begin
                left_or = left_or | left_terms[k];
                top_or  = top_or | top_terms[k];
            end
        end

        assign left_lane[i] = left_or;
        assign top_lane[i]  = top_or;
    end

    for (genvar s = 0; s < N * N; s++) begin : g_slice
        if (s % N == 0) begin : g_left
            assign left_bus[s] = left_lane[s / N];
        end else begin : g_left_zero
            assign left_bus[s] = '0;
        end

        if (s < N) begin : g_top
            assign top_bus[s] = top_lane[s];
        end else begin : g_top_zero
            assign top_bus[s] = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            a_q         <= '0;
            b_q         <= '0;
            array_clear <= 1'b0;
            data_in_1   <= '0;
            data_in_a   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            array_clear <= 1'b0;
            done        <= 1'b0;
            data_in_1   <= '0;
            data_in_a   <= '0;

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        a_q         <= mat_a;
                        b_q         <= mat_b;
                        array_clear <= 1'b1;
                        busy        <= 1'b1;
                        state       <= ST_CLEAR;
                    end
                end

                ST_CLEAR: begin
                    cnt       <= '0;
                    data_in_1 <= left_bus;
                    data_in_a <= top_bus;
                    state     <= ST_FEED;
                end

                ST_FEED: begin
                    if (cnt == FEED_LAST) begin
                        cnt   <= FLUSH_LOAD;
                        state <= ST_FLUSH;
                    end else begin
                        cnt       <= cnt + 1'b1;
                        data_in_1 <= left_bus;
                        data_in_a <= top_bus;
                    end
                end

                // Down-count from FLUSH_CYC to zero inclusive, so done lands 2N+FLUSH_CYC+2
                // cycles after start and jobs repeat every 2N+FLUSH_CYC+3 cycles.
                ST_FLUSH: begin
                    if (cnt == '0) begin
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                ST_DONE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end

                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sys_array_feeder.sv
// Self-checking bench for sys_array_feeder: cycle-level job model, directed skew table,
// behavioural systolic product check, and randomized start/reset traffic.
module tb_sys_array_feeder;
    import sys_array_pkg::*;

    localparam int FLUSH_CYC = 4;
    localparam int JOB_LEN   = 2 * N + FLUSH_CYC + 2;
    localparam int FEED_LEN  = 2 * N - 1;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [BUS_W-1:0] mat_a;
    logic [BUS_W-1:0] mat_b;
    logic             array_clear;
    logic [BUS_W-1:0] data_in_1;
    logic [BUS_W-1:0] data_in_a;
    logic             busy;
    logic             done;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit chk_en   = 1'b0;

    sys_array_feeder #(.FLUSH_CYC(FLUSH_CYC)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .mat_a      (mat_a),
        .mat_b      (mat_b),
        .array_clear(array_clear),
        .data_in_1  (data_in_1),
        .data_in_a  (data_in_a),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Reference model: phase = cycles since the accepting edge (0 = idle).
    int                phase = 0;
    logic [DATA_W-1:0] ma [N][N];
    logic [DATA_W-1:0] mb [N][N];

    always @(posedge clk) begin
        if (reset) begin
            phase = 0;
            for (int r = 0; r < N; r++)
                for (int c = 0; c < N; c++) begin
                    ma[r][c] = '0;
                    mb[r][c] = '0;
                end
        end else if (phase == 0) begin
            if (start) begin
                phase = 1;
                for (int r = 0; r < N; r++)
                    for (int c = 0; c < N; c++) begin
                        ma[r][c] = mat_a[(r*N+c)*DATA_W +: DATA_W];
                        mb[r][c] = mat_b[(r*N+c)*DATA_W +: DATA_W];
                    end
            end
        end else if (phase == JOB_LEN) begin
            phase = 0;
        end else begin
            phase++;
        end
    end

    function automatic logic [BUS_W-1:0] exp_left();
        logic [BUS_W-1:0] e = '0;
        if (phase >= 2 && phase <= 2 * N) begin
            int t = phase - 2;
            for (int i = 0; i < N; i++)
                if (t - i >= 0 && t - i < N) e[(i*N)*DATA_W +: DATA_W] = ma[i][t-i];
        end
        return e;
    endfunction

    function automatic logic [BUS_W-1:0] exp_top();
        logic [BUS_W-1:0] e = '0;
        if (phase >= 2 && phase <= 2 * N) begin
            int t = phase - 2;
            for (int j = 0; j < N; j++)
                if (t - j >= 0 && t - j < N) e[j*DATA_W +: DATA_W] = mb[t-j][j];
        end
        return e;
    endfunction

    task automatic check(input string name, input logic [BUS_W-1:0] act, input logic [BUS_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("array_clear", BUS_W'(array_clear), BUS_W'(phase == 1));
            check("busy", BUS_W'(busy), BUS_W'(phase >= 1 && phase <= JOB_LEN));
            check("done", BUS_W'(done), BUS_W'(phase == JOB_LEN));
            check("data_in_1", data_in_1, exp_left());
            check("data_in_a", data_in_a, exp_top());
        end
    end

    function automatic logic [BUS_W-1:0] rand_bus();
        logic [BUS_W-1:0] b;
        for (int s = 0; s < N * N; s++) b[s*DATA_W +: DATA_W] = DATA_W'($urandom);
        return b;
    endfunction

    function automatic longint ref_sum(input logic [BUS_W-1:0] a, input logic [BUS_W-1:0] b);
        longint acc = 0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                for (int k = 0; k < N; k++)
                    acc += longint'(a[(i*N+k)*DATA_W +: DATA_W]) * longint'(b[(k*N+j)*DATA_W +: DATA_W]);
        return acc;
    endfunction

    // Runs one job from IDLE, records the edge lanes, and sums what an N x N array would accumulate.
    task automatic run_job(input logic [BUS_W-1:0] a, input logic [BUS_W-1:0] b, output longint res);
        logic [DATA_W-1:0] hl [FEED_LEN][N];
        logic [DATA_W-1:0] ht [FEED_LEN][N];
        mat_a = a;
        mat_b = b;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int off = 1; off <= JOB_LEN; off++) begin
            @(negedge clk);
            if (off >= 2 && off <= 2 * N)
                for (int l = 0; l < N; l++) begin
                    hl[off-2][l] = data_in_1[(l*N)*DATA_W +: DATA_W];
                    ht[off-2][l] = data_in_a[l*DATA_W +: DATA_W];
                end
        end
        check("job_done_pulse", BUS_W'(done), BUS_W'(1));
        res = 0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                for (int tau = 0; tau <= 4 * N; tau++) begin
                    int tl = tau - j;
                    int tt = tau - i;
                    if (tl >= 0 && tl < FEED_LEN && tt >= 0 && tt < FEED_LEN)
                        res += longint'(hl[tl][i]) * longint'(ht[tt][j]);
                end
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic              clear;
        logic              bsy;
        logic              dn;
        int                s1;
        logic [DATA_W-1:0] v1;
        int                sa;
        logic [DATA_W-1:0] va;
    } vec_t;

    vec_t   vecs [JOB_LEN+1];
    longint res;
    int     stamps [3];
    int     ndone;

    initial begin
        // offset 1..13 after the accepting edge, A = 1..9, B = 10..90 row-major
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 0, 16'd0, 0, 16'd0};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 0, 16'd1, 0, 16'd10};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 3, 16'd4, 1, 16'd20};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 6, 16'd7, 2, 16'd30};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 6, 16'd8, 2, 16'd60};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 6, 16'd9, 2, 16'd90};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 6, 16'd0, 2, 16'd0};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 0, 16'd0, 0, 16'd0};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 0, 16'd0, 1, 16'd0};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 3, 16'd0, 0, 16'd0};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 0, 16'd0, 0, 16'd0};
        vecs[11] = '{1'b0, 1'b1, 1'b1, 0, 16'd0, 0, 16'd0};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 0, 16'd0, 0, 16'd0};

        reset = 1'b1;
        start = 1'b0;
        mat_a = '0;
        mat_b = '0;
        @(posedge clk);
        chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset_busy", BUS_W'(busy), '0);
        check("reset_done", BUS_W'(done), '0);
        check("reset_clear", BUS_W'(array_clear), '0);
        check("reset_bus1", data_in_1, '0);
        check("reset_busa", data_in_a, '0);

        // Identity A times B = 1..9: summed product is 45
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                mat_a[(r*N+c)*DATA_W +: DATA_W] = (r == c) ? 16'd1 : 16'd0;
                mat_b[(r*N+c)*DATA_W +: DATA_W] = DATA_W'(r * N + c + 1);
            end
        run_job(mat_a, mat_b, res);
        check("identity_result", BUS_W'(res), BUS_W'(45));

        // Skew table, with a stray start mid-job that must be ignored
        for (int s = 0; s < N * N; s++) begin
            mat_a[s*DATA_W +: DATA_W] = DATA_W'(s + 1);
            mat_b[s*DATA_W +: DATA_W] = DATA_W'(10 * (s + 1));
        end
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int k = 0; k <= JOB_LEN; k++) begin
            @(negedge clk);
            check("tbl_clear", BUS_W'(array_clear), BUS_W'(vecs[k].clear));
            check("tbl_busy", BUS_W'(busy), BUS_W'(vecs[k].bsy));
            check("tbl_done", BUS_W'(done), BUS_W'(vecs[k].dn));
            check("tbl_slice1", BUS_W'(data_in_1[vecs[k].s1*DATA_W +: DATA_W]), BUS_W'(vecs[k].v1));
            check("tbl_slicea", BUS_W'(data_in_a[vecs[k].sa*DATA_W +: DATA_W]), BUS_W'(vecs[k].va));
            if (k == 3) begin
                check("tbl_a_slice6_zero", BUS_W'(data_in_a[6*DATA_W +: DATA_W]), '0);
                start = 1'b1;
            end
            if (k == 4) start = 1'b0;
        end

        // Reset during FEED t=2, then a fresh job
        mat_a = rand_bus();
        mat_b = rand_bus();
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("abort_busy", BUS_W'(busy), '0);
        check("abort_bus1", data_in_1, '0);
        check("abort_busa", data_in_a, '0);
        mat_a = rand_bus();
        mat_b = rand_bus();
        run_job(mat_a, mat_b, res);
        check("after_abort_result", BUS_W'(res), BUS_W'(ref_sum(mat_a, mat_b)));

        // start and reset together in IDLE: no job
        start = 1'b1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("start_reset_busy", BUS_W'(busy), '0);
            check("start_reset_clear", BUS_W'(array_clear), '0);
        end

        // start held for three jobs, operands changing every cycle
        ndone = 0;
        start = 1'b1;
        for (int c = 0; c < 4 * (JOB_LEN + 1) + 10 && ndone < 3; c++) begin
            @(negedge clk);
            if (done) begin
                stamps[ndone] = cyc;
                ndone++;
            end
            mat_a = rand_bus();
            mat_b = rand_bus();
        end
        start = 1'b0;
        check("b2b_done_count", BUS_W'(ndone), BUS_W'(3));
        if (ndone == 3) begin
            check("b2b_period_1", BUS_W'(stamps[1] - stamps[0]), BUS_W'(JOB_LEN + 1));
            check("b2b_period_2", BUS_W'(stamps[2] - stamps[1]), BUS_W'(JOB_LEN + 1));
        end

        // Random start/reset traffic, checked cycle by cycle against the model
        for (int it = 0; it < 30; it++) begin
            repeat ($urandom_range(0, 15)) @(posedge clk);
            #1;
            mat_a = rand_bus();
            mat_b = rand_bus();
            start = 1'b1;
            reset = ($urandom_range(0, 7) == 0);
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
            start = 1'b0;
            reset = 1'b0;
        end
        repeat (JOB_LEN + 2) @(posedge clk);
        #1;

        mat_a = rand_bus();
        mat_b = rand_bus();
        run_job(mat_a, mat_b, res);
        check("random_result", BUS_W'(res), BUS_W'(ref_sum(mat_a, mat_b)));

        @(negedge clk);
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
